// File: rtl/addsub_if.sv
// Valid/ready operand and result bundle for addsub_pipe.
interface addsub_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (output in_valid, A, B, cin, out_ready,
                    input  in_ready, out_valid, Result, Cout, ovf, zero, neg);
    modport slave  (input  in_valid, A, B, cin, out_ready,
                    output in_ready, out_valid, Result, Cout, ovf, zero, neg);
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: ripple chain cut into STAGES registered slices.
// Optional signed saturation of Result is enabled by defining ADDSUB_SAT_EN.
module addsub_pipe #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input logic     clk,
    input logic     rst_n,
    addsub_if.slave bus
);
    localparam int CH = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] vld_p;
    logic [STAGES:0]   vld_chain;
    logic [STAGES-1:0] ld;

    logic [WIDTH-1:0] a_p  [STAGES];
    logic [WIDTH-1:0] b_p  [STAGES];
    logic [WIDTH-1:0] r_p  [STAGES];
    logic             c_p  [STAGES];

    logic [WIDTH-1:0] a_nx [STAGES];
    logic [WIDTH-1:0] b_nx [STAGES];
    logic [WIDTH-1:0] r_nx [STAGES];
    logic             c_nx [STAGES];

    logic [WIDTH-1:0] ta, tb, tr;
    logic             tc;

    logic signed [WIDTH-1:0] raw_res;
    logic signed [WIDTH-1:0] res_nx;
    logic                    raw_cout;
    logic                    sgn_a, sgn_b;
    logic                    ovf_nx;
    logic                    zero_nx;
    logic                    neg_nx;

`ifdef ADDSUB_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH-1:0] raw,
                                                       input logic ov, input logic sgn);
        if (!ov)
            return raw;
        return sgn ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // A stage loads when empty or when its content moves on; evaluated from the output back.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !vld_p[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            ld[k] = !vld_p[k] || ld[k+1];
    end

    assign vld_chain     = {vld_p, bus.in_valid};
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_p[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (ld[k])
                    vld_p[k] <= vld_chain[k];
        end
    end

    // Slice k ripples bits [k*CH, (k+1)*CH) using the carry held by the previous stage.
    always_comb begin
        ta = bus.A;
        tb = bus.B ^ {WIDTH{bus.cin}};
        tr = '0;
        tc = bus.cin;
        for (int k = 0; k < STAGES; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= k * CH && i < (k + 1) * CH) begin
                    tr[i] = ta[i] ^ tb[i] ^ tc;
                    tc    = (ta[i] & tb[i]) | (tc & (ta[i] ^ tb[i]));
                end
            end
            a_nx[k] = ta;
            b_nx[k] = tb;
            r_nx[k] = tr;
            c_nx[k] = tc;
            if (k < STAGES - 1) begin
                ta = a_p[k];
                tb = b_p[k];
                tr = r_p[k];
                tc = c_p[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k] && vld_chain[k]) begin
                a_p[k] <= a_nx[k];
                b_p[k] <= b_nx[k];
                r_p[k] <= r_nx[k];
                c_p[k] <= c_nx[k];
            end
        end
    end

    // ---- last stage: flags and optional clamp, registered with Result ----
    assign raw_res  = r_nx[STAGES-1];
    assign raw_cout = c_nx[STAGES-1];
    assign sgn_a    = a_nx[STAGES-1][WIDTH-1];
    assign sgn_b    = b_nx[STAGES-1][WIDTH-1];
    assign ovf_nx   = (sgn_a == sgn_b) && (raw_res[WIDTH-1] != sgn_a);

`ifdef ADDSUB_SAT_EN
    assign res_nx = sat_fn(raw_res, ovf_nx, sgn_a);
`else
    assign res_nx = raw_res;
`endif

    assign zero_nx = (res_nx == '0);
    assign neg_nx  = res_nx[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Result <= '0;
            bus.Cout   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
            bus.neg    <= 1'b0;
        end else if (ld[STAGES-1] && vld_chain[STAGES-1]) begin
            bus.Result <= res_nx;
            bus.Cout   <= raw_cout;
            bus.ovf    <= ovf_nx;
            bus.zero   <= zero_nx;
            bus.neg    <= neg_nx;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed cases on a STAGES=2 instance plus random sweep over STAGES 1/2/3/5.
module tb_addsub_pipe;
    localparam int W  = 5;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         iv   [NI];
    logic [W-1:0] ia   [NI];
    logic [W-1:0] ib   [NI];
    logic         ic   [NI];
    logic         ordy [NI];
    logic         ir   [NI];
    logic         ov   [NI];
    logic [W-1:0] ores [NI];
    logic         oco  [NI];
    logic         oovf [NI];
    logic         oz   [NI];
    logic         ong  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
        addsub_if #(.WIDTH(W)) bus ();
        addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign bus.in_valid  = iv[g];
        assign bus.A         = ia[g];
        assign bus.B         = ib[g];
        assign bus.cin       = ic[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]   = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign ores[g] = bus.Result;
        assign oco[g]  = bus.Cout;
        assign oovf[g] = bus.ovf;
        assign oz[g]   = bus.zero;
        assign ong[g]  = bus.neg;
    end

    function automatic int stg(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 5;
    endfunction

    // Reference: {Result, Cout, ovf, zero, neg} from integer arithmetic.
    function automatic logic [8:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0]   s;
        logic [W-1:0] r;
        int           sa, sb, t;
        logic         o;
        s  = {1'b0, a} + {1'b0, (c ? ~b : b)} + (W+1)'(c);
        r  = s[W-1:0];
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = c ? sa - sb : sa + sb;
        o  = (t > 15) || (t < -16);
`ifdef ADDSUB_SAT_EN
        if (t > 15)       r = 5'b01111;
        else if (t < -16) r = 5'b10000;
`endif
        return {r, s[W], o, (r == 5'd0), r[W-1]};
    endfunction

    function automatic logic [8:0] outs(input int g);
        return {ores[g], oco[g], oovf[g], oz[g], ong[g]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one transaction to an idle instance and wait for it at the output.
    task automatic send_wait(input int g, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             output logic [8:0] got, output int lat);
        ia[g] = a; ib[g] = b; ic[g] = c; iv[g] = 1'b1; ordy[g] = 1'b1;
        step();
        iv[g] = 1'b0;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            if (ov[g]) begin
                lat = n;
                break;
            end
            step();
        end
        got = outs(0 + g);
        step();
    endtask

    task automatic test_reset();
        int emitted;
        step();
        step();
        n_checks++;
        if ({ov[0], outs(0)} !== 10'd0) begin
            n_fail++; $display("FAIL reset_hold: got %b required 0", {ov[0], outs(0)});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b required 1", ir[0]);
        end
        ordy[0] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            ia[0] = 5'($urandom); ib[0] = 5'($urandom); ic[0] = 1'($urandom); iv[0] = 1'b1;
            step();
        end
        iv[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_inflight: out_valid %b required 1", ov[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov[0], outs(0)} !== 10'd0) begin
            n_fail++; $display("FAIL reset_async: got %b required 0", {ov[0], outs(0)});
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({ir[0], ov[0]} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: in_ready,out_valid %b required 10", {ir[0], ov[0]});
        end
        ordy[0] = 1'b1;
        emitted = 0;
        repeat (5) begin
            step();
            if (ov[0] !== 1'b0) emitted++;
        end
        n_checks++;
        if (emitted !== 0) begin
            n_fail++; $display("FAIL reset_discard: emitted %0d required 0", emitted);
        end
    endtask

    task automatic test_add();
        logic [8:0] got;
        int lat;
        send_wait(0, 5'b00111, 5'b00011, 1'b0, got, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL add_latency: got %0d required 1", lat);
        end
        n_checks++;
        if (got !== 9'b01010_0000) begin
            n_fail++; $display("FAIL add: got %b required %b", got, 9'b01010_0000);
        end
    endtask

    task automatic test_sub();
        logic [8:0] got;
        int lat;
        send_wait(0, 5'b00011, 5'b00111, 1'b1, got, lat);
        n_checks++;
        if (got !== 9'b11100_0001) begin
            n_fail++; $display("FAIL sub_neg: got %b required %b", got, 9'b11100_0001);
        end
        send_wait(0, 5'b00101, 5'b00101, 1'b1, got, lat);
        n_checks++;
        if (got !== 9'b00000_1010) begin
            n_fail++; $display("FAIL sub_zero: got %b required %b", got, 9'b00000_1010);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] got, e1, e2;
        int lat;
`ifdef ADDSUB_SAT_EN
        e1 = 9'b01111_0100;
        e2 = 9'b10000_1101;
`else
        e1 = 9'b10000_0101;
        e2 = 9'b01111_1100;
`endif
        send_wait(0, 5'b01111, 5'b00001, 1'b0, got, lat);
        n_checks++;
        if (got !== e1) begin
            n_fail++; $display("FAIL ovf_pos: got %b required %b", got, e1);
        end
        send_wait(0, 5'b10000, 5'b00001, 1'b1, got, lat);
        n_checks++;
        if (got !== e2) begin
            n_fail++; $display("FAIL ovf_neg: got %b required %b", got, e2);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] xa [3];
        logic [W-1:0] xb [3];
        logic         xc [3];
        logic [8:0]   held;
        int           stable;
        for (int t = 0; t < 3; t++) begin
            xa[t] = 5'($urandom); xb[t] = 5'($urandom); xc[t] = 1'($urandom);
        end
        ordy[0] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            ia[0] = xa[t]; ib[0] = xb[t]; ic[0] = xc[t]; iv[0] = 1'b1;
            #1;
            n_checks++;
            if (ir[0] !== 1'b1) begin
                n_fail++; $display("FAIL bp_accept%0d: in_ready %b required 1", t, ir[0]);
            end
            step();
        end
        ia[0] = xa[2]; ib[0] = xb[2]; ic[0] = xc[2];
        #1;
        n_checks++;
        if (ir[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: in_ready %b required 0", ir[0]);
        end
        held = outs(0);
        stable = 1;
        repeat (5) begin
            step();
            if (ov[0] !== 1'b1 || outs(0) !== held || ir[0] !== 1'b0) stable = 0;
        end
        n_checks++;
        if (stable !== 1) begin
            n_fail++; $display("FAIL bp_stable: outputs changed while stalled, last %b held %b", outs(0), held);
        end
        n_checks++;
        if (held !== model(xa[0], xb[0], xc[0])) begin
            n_fail++; $display("FAIL bp_first: got %b required %b", held, model(xa[0], xb[0], xc[0]));
        end
        ordy[0] = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume: in_ready %b required 1", ir[0]);
        end
        step();
        iv[0] = 1'b0;
        for (int t = 1; t < 3; t++) begin
            n_checks++;
            if ({ov[0], outs(0)} !== {1'b1, model(xa[t], xb[t], xc[t])}) begin
                n_fail++; $display("FAIL bp_order%0d: got %b required %b", t, {ov[0], outs(0)},
                                   {1'b1, model(xa[t], xb[t], xc[t])});
            end
            step();
        end
        n_checks++;
        if (ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: out_valid %b required 0", ov[0]);
        end
    endtask

    task automatic test_latency();
        int         lat [NI];
        logic [8:0] got [NI];
        logic [8:0] exp [NI];
        for (int g = 0; g < NI; g++) begin
            ia[g] = 5'($urandom); ib[g] = 5'($urandom); ic[g] = 1'($urandom);
            exp[g] = model(ia[g], ib[g], ic[g]);
            iv[g] = 1'b1; ordy[g] = 1'b1; lat[g] = -1; got[g] = '0;
        end
        step();
        for (int g = 0; g < NI; g++) iv[g] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            for (int g = 0; g < NI; g++) begin
                if (lat[g] < 0 && ov[g] === 1'b1) begin
                    lat[g] = n;
                    got[g] = outs(g);
                end
            end
            step();
        end
        for (int g = 0; g < NI; g++) begin
            n_checks++;
            if (lat[g] !== stg(g) - 1) begin
                n_fail++; $display("FAIL latency_s%0d: got %0d required %0d", stg(g), lat[g], stg(g) - 1);
            end
            n_checks++;
            if (got[g] !== exp[g]) begin
                n_fail++; $display("FAIL latency_data_s%0d: got %b required %b", stg(g), got[g], exp[g]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [8:0] q [NI][$];
        logic [8:0] e;
        for (int cyc = 0; cyc < 450; cyc++) begin
            for (int g = 0; g < NI; g++) begin
                if (cyc < 400) begin
                    iv[g]   = ($urandom_range(0, 99) < 70);
                    ia[g]   = 5'($urandom);
                    ib[g]   = 5'($urandom);
                    ic[g]   = 1'($urandom);
                    ordy[g] = 1'($urandom);
                end else begin
                    iv[g]   = 1'b0;
                    ordy[g] = 1'b1;
                end
            end
            #1;
            for (int g = 0; g < NI; g++) begin
                if (ov[g] && ordy[g]) begin
                    n_checks++;
                    if (q[g].size() == 0) begin
                        n_fail++; $display("FAIL sweep_extra_s%0d: output %b with nothing outstanding", stg(g), outs(g));
                    end else begin
                        e = q[g].pop_front();
                        if (outs(g) !== e) begin
                            n_fail++; $display("FAIL sweep_s%0d: cycle %0d got %b required %b", stg(g), cyc, outs(g), e);
                        end
                    end
                end
                if (iv[g] && ir[g]) q[g].push_back(model(ia[g], ib[g], ic[g]));
            end
            step();
        end
        for (int g = 0; g < NI; g++) begin
            n_checks++;
            if (q[g].size() !== 0) begin
                n_fail++; $display("FAIL sweep_drain_s%0d: %0d outstanding required 0", stg(g), q[g].size());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            iv[g] = 1'b0; ia[g] = '0; ib[g] = '0; ic[g] = 1'b0; ordy[g] = 1'b1;
        end
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_latency();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor; the next-generation arithmetic slice of the ALU datapath. The WIDTH-bit ripple carry chain is split into STAGES registered slices, with a valid/ready handshake on both sides. The final stage produces carry, signed-overflow, zero and negative flags.

Parameters:
WIDTH, 5, operand/result width in bits (>=2)
STAGES, 2, number of pipeline slices, 1..WIDTH; slice width CH = ceil(WIDTH/STAGES); last slice takes the remainder

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction offered
in_ready  output  1  block can accept a transaction this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cin  input  1  op select: 0 = A+B, 1 = A-B (B inverted, carry-in 1)
out_valid  output  1  Result/flags hold a valid transaction
out_ready  input  1  downstream accepts Result this cycle
Result  output  WIDTH  sum/difference, mod 2^WIDTH (saturated if feature on)
Cout  output  1  carry out of MSB; on subtract 1 = no borrow (A>=B unsigned)
ovf  output  1  signed overflow: operand signs (A, B^cin) equal and result sign differs
zero  output  1  Result == 0 (after saturation)
neg  output  1  Result[WIDTH-1]

Behaviour:
- Reset (async, rst_n=0): all stage valid bits cleared; out_valid=0; Result, Cout, ovf, zero, neg = 0. Any in-flight transactions are discarded. in_ready=1 on the first cycle after release.
- Accept: transaction taken on a rising edge with in_valid && in_ready. A, B and cin are sampled only at that edge.
- Stage k (0..STAGES-1) adds bits [k*CH .. min((k+1)*CH, WIDTH)-1] of A and (B ^ {WIDTH{cin}}).
  - Carry-in: cin for k=0; the registered carry from stage k-1 otherwise.
  - Lower result bits and unused upper operand bits travel forward in the stage registers.
- Flags are computed combinationally from the final stage's register contents and registered with Result in the last stage.
- Latency: a transaction accepted at edge t is presented with out_valid=1 after edge t+STAGES-1. With STAGES=1 it is presented after edge t. No stalls give throughput of 1 per cycle.
- Flow control: stage k loads when it is empty or stage k+1 loads or drains this cycle.
  - Last stage drains on out_valid && out_ready.
  - in_ready = !stage0_valid || stage0_advances. This is combinational from out_ready through the chain, with no combinational path from in_valid.
  - Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Full: all STAGES slices valid and out_ready=0 -> in_ready=0. Result and flags stay stable while out_valid && !out_ready.
- Simultaneous accept and drain when full: both occur and occupancy is unchanged.
- Empty: out_valid=0. Output data holds its last value and is don't-care for checking.
- Wrap-around: without saturation, Result = (A + (B^mask) + cin) mod 2^WIDTH. Cout is bit WIDTH of that sum.
- Ordering: strictly in order; no drops or duplication.

Optional Feature:
ADDSUB_SAT_EN
- Defined: when ovf=1, Result clamps to the signed limit. Positive overflow gives 0 followed by all ones; negative overflow gives 1 followed by all zeros.
  - ovf and Cout still report the raw unsaturated condition. zero and neg reflect the clamped Result.
  - Clamping is applied in the last stage with no added latency.
- Undefined: no clamping, results wrap, and no saturation logic is generated.

Test Plan (WIDTH=5, STAGES=2 unless stated):
- Reset: assert rst_n=0 mid-stream with 2 transactions in flight -> out_valid=0 and all outputs 0 immediately; after release in_ready=1 and nothing emitted.
- Add: A=00111, B=00011, cin=0, out_ready=1 -> one cycle after the accept edge: Result=01010, Cout=0, ovf=0, zero=0, neg=0.
- Subtract: A=00011, B=00111, cin=1 -> Result=11100, Cout=0, neg=1, ovf=0. Then A=00101, B=00101, cin=1 -> Result=00000, Cout=1, zero=1.
- Overflow: A=01111, B=00001, cin=0 -> Result=10000, ovf=1, Cout=0 (with ADDSUB_SAT_EN: Result=01111, neg=0). Then A=10000, B=00001, cin=1 -> Result=01111, ovf=1, Cout=1 (SAT: Result=10000).
- Backpressure: out_ready=0, offer 3 back-to-back transactions -> 2 accepted and in_ready=0 on the third. Outputs stay stable for 5 cycles. Raise out_ready -> 3 results in order, one per cycle.
- Sweep at STAGES=1, 3 and 5 with random A, B, cin and random out_ready (50%) -> scoreboard matches the reference model; observed latency equals STAGES-1 edges after acceptance when unstalled.
